// File: rtl/bcd_disp_pkg.sv
// Shared types and display constants for the two-digit seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}; anode selects are active-low.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIG0 = 2'd1,
    ST_DIG1 = 2'd2
  } state_t;

  // Frame snapshot: everything that may appear on the display for one frame.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       co;
  } snap_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are not decimal digits and render as a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Two-digit common-anode seven-segment scanner with per-frame input snapshot.
// Optional feature: define BCD_SCAN_LEADING_ZERO_BLANK_EN to blank a leading tens zero.
module bcd_7seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic       enable,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic       co,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  snap_t         snap, snap_nx;
  logic [1:0]    an_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic [3:0]    dec_in;
  logic [6:0]    dec_seg;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    snap_nx  = snap;
    if (!enable) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          snap_nx  = '{tens: d2, ones: d1, co: co};
          cnt_nx   = '0;
          state_nx = ST_DIG0;
        end
        ST_DIG0: begin
          if (cnt == TC) begin
            cnt_nx   = '0;
            state_nx = ST_DIG1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_DIG1: begin
          if (cnt == TC) begin
            snap_nx  = '{tens: d2, ones: d1, co: co};
            cnt_nx   = '0;
            state_nx = ST_DIG0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state/snapshot so the registered pins
  // change on the same edge as the state transition.
  assign dec_in = (state_nx == ST_DIG1) ? snap_nx.tens : snap_nx.ones;

  bcd_to_7seg u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  always_comb begin
    an_nx  = AN_OFF;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    unique case (state_nx)
      ST_DIG0: begin
        an_nx  = AN_ONES;
        seg_nx = dec_seg;
      end
      ST_DIG1: begin
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        if (snap_nx.tens != 4'd0) begin
          an_nx  = AN_TENS;
          seg_nx = dec_seg;
          dp_nx  = ~snap_nx.co;
        end
`else
        an_nx  = AN_TENS;
        seg_nx = dec_seg;
        dp_nx  = ~snap_nx.co;
`endif
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      snap  <= '0;
      an    <= AN_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      snap  <= snap_nx;
      an    <= an_nx;
      seg   <= seg_nx;
      dp    <= dp_nx;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed scoreboard bench for bcd_7seg_scan with REFRESH_DIV = 4.
// Expected {an,seg,dp} words are queued per cycle, then drained one per clock.
module tb_bcd_7seg_scan;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000, PDASH = 7'b0111111, POFF = 7'b1111111;

  typedef struct {
    logic [9:0] exp;
    logic [9:0] mask;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       n_clr, enable, co;
  logic [3:0] d1, d2;
  logic [1:0] an;
  logic [6:0] seg;
  logic       dp;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  bcd_7seg_scan #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .n_clr  (n_clr),
    .enable (enable),
    .d1     (d1),
    .d2     (d2),
    .co     (co),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [1:0] a, input logic [6:0] s,
                      input logic p, input int n, input logic [9:0] mask = '1);
    for (int i = 0; i < n; i++) q.push_back('{exp: {a, s, p}, mask: mask, tag: tag});
  endtask

  task automatic compare(input exp_t e);
    logic [9:0] obs;
    obs = {an, seg, dp};
    checks++;
    assert ((obs & e.mask) === (e.exp & e.mask)) else begin
      fails++;
      $error("FAIL %s: an/seg/dp got %b/%b/%b expected %b/%b/%b (mask %b)", e.tag,
             obs[9:8], obs[7:1], obs[0], e.exp[9:8], e.exp[7:1], e.exp[0], e.mask);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      compare(e);
    end
  endtask

  task automatic check_now(input string tag, input logic [1:0] a, input logic [6:0] s, input logic p);
    compare('{exp: {a, s, p}, mask: '1, tag: tag});
  endtask

  initial begin
    n_clr = 1'b1; enable = 1'b0; d1 = 4'd0; d2 = 4'd0; co = 1'b0;

    // Reset with no clock running.
    #2 n_clr = 1'b0;
    #2 check_now("reset_no_clk", 2'b11, POFF, 1'b1);
    #2 n_clr = 1'b1;
    clk_run = 1'b1;
    push("idle_dark", 2'b11, POFF, 1'b1, 2);
    drain();

    // Scan 79: first digit one cycle after enable, 4 cycles per slot, repeating.
    d1 = 4'd7; d2 = 4'd9; co = 1'b0; enable = 1'b1;
    push("scan_ones", 2'b10, P7, 1'b1, 4);
    push("scan_tens", 2'b01, P9, 1'b1, 4);
    push("scan_ones_rep", 2'b10, P7, 1'b1, 4);
    push("scan_tens_rep", 2'b01, P9, 1'b1, 2);
    drain();

    // d1 changes mid-DIG1: new ones digit only appears after the DIG1->DIG0 snapshot.
    d1 = 4'd5;
    push("snap_tens_hold", 2'b01, P9, 1'b1, 2);
    push("snap_ones_new", 2'b10, P5, 1'b1, 4);
    drain();

    // Saturation: co=1 must light dp only in the tens slot of the next frame.
    d1 = 4'd9; d2 = 4'd9; co = 1'b1;
    push("sat_not_yet", 2'b01, P9, 1'b1, 4);
    push("sat_ones_dp_off", 2'b10, P9, 1'b1, 4);
    drain();
    d1 = 4'd12;
    push("sat_tens_dp_on", 2'b01, P9, 1'b0, 4);
    push("invalid_dash", 2'b10, PDASH, 1'b1, 4);
    push("sat_tens_dp_on2", 2'b01, P9, 1'b0, 4);
    drain();

    // Enable dropped two cycles into DIG0, then restart with a full slot.
    d1 = 4'd2; d2 = 4'd4; co = 1'b0;
    push("en_ones", 2'b10, P2, 1'b1, 2);
    drain();
    enable = 1'b0;
    push("en_off_dark", 2'b11, POFF, 1'b1, 3);
    drain();
    d1 = 4'd1; d2 = 4'd6; enable = 1'b1;
    push("reen_ones", 2'b10, P1, 1'b1, 4);
    push("reen_tens", 2'b01, P6, 1'b1, 4);
    push("reen_ones2", 2'b10, P1, 1'b1, 4);
    drain();

    // Enable falls on the DIG0 terminal-count edge: IDLE wins over DIG1.
    enable = 1'b0; d1 = 4'd8;
    push("en_off_at_tc", 2'b11, POFF, 1'b1, 2);
    drain();

    // Reset asserted mid-DIG1 darkens immediately, then a fresh start.
    d1 = 4'd4; d2 = 4'd8; co = 1'b1; enable = 1'b1;
    push("pre_rst_ones", 2'b10, P4, 1'b1, 4);
    push("pre_rst_tens", 2'b01, P8, 1'b0, 2);
    drain();
    #2 n_clr = 1'b0;
    #1 check_now("rst_mid_dig1", 2'b11, POFF, 1'b1);
    @(negedge clk);
    check_now("rst_held", 2'b11, POFF, 1'b1);
    n_clr = 1'b1;
    push("post_rst_ones", 2'b10, P4, 1'b1, 4);
    push("post_rst_tens", 2'b01, P8, 1'b0, 4);
    drain();

    // Tens digit zero: blanked when the leading-zero option is built in, shown as 0 otherwise.
    enable = 1'b0;
    push("pre_blank_idle", 2'b11, POFF, 1'b1, 1);
    drain();
    d1 = 4'd3; d2 = 4'd0; co = 1'b1; enable = 1'b1;
    push("zero_ones", 2'b10, P3, 1'b1, 4);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    push("zero_tens_blank", 2'b11, POFF, 1'b1, 4, 10'b11_0000000_1);
`else
    push("zero_tens_shown", 2'b01, P0, 1'b0, 4);
`endif
    push("zero_ones_again", 2'b10, P3, 1'b1, 4);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
